// File: rtl/stream_downsizer_pkg.sv
// Shared types and constants for the stream width down-converter.
// Beat-order encodings for MSB_FIRST, plus the two-state FSM encoding.
package stream_downsizer_pkg;

  localparam bit ORDER_LSB_FIRST = 1'b0;
  localparam bit ORDER_MSB_FIRST = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/stream_downsizer.sv
// Splits each IN_SIZE-bit word into RATIO OUT_SIZE-bit beats; a new word may be
// taken on the same cycle the final beat of the current one leaves.
module stream_downsizer
  import stream_downsizer_pkg::*;
#(
  parameter int IN_SIZE   = 32,
  parameter int OUT_SIZE  = 8,
  parameter int RATIO     = IN_SIZE / OUT_SIZE,
  parameter int LOG2RATIO = $clog2(RATIO),
  parameter bit MSB_FIRST = ORDER_LSB_FIRST
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [IN_SIZE-1:0]  s_data,
  input  logic                s_last,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [OUT_SIZE-1:0] m_data,
  output logic                m_last
);

  if ((IN_SIZE % OUT_SIZE) != 0) begin : g_bad_multiple
    $error("stream_downsizer: IN_SIZE must be an exact multiple of OUT_SIZE");
  end
  if (RATIO != IN_SIZE / OUT_SIZE || RATIO < 2) begin : g_bad_ratio
    $error("stream_downsizer: RATIO must equal IN_SIZE/OUT_SIZE and be at least 2");
  end

  localparam logic [LOG2RATIO-1:0] LAST_IDX = LOG2RATIO'(RATIO - 1);

  state_e               state_q, state_d;
  logic [LOG2RATIO-1:0] idx_q, idx_d;
  logic [IN_SIZE-1:0]   buf_q, buf_d;
  logic                 lst_q, lst_d;

  logic busy;
  logic last_beat;
  logic w_hs;
  logic r_hs;

  // Beat order is folded into the slice table so the mux is always indexed by idx.
  logic [OUT_SIZE-1:0] slice [RATIO];
  for (genvar gi = 0; gi < RATIO; gi++) begin : g_slice
    if (MSB_FIRST == ORDER_MSB_FIRST) begin : g_msb
      assign slice[gi] = buf_q[(RATIO-1-gi)*OUT_SIZE +: OUT_SIZE];
    end else begin : g_lsb
      assign slice[gi] = buf_q[gi*OUT_SIZE +: OUT_SIZE];
    end
  end

  assign busy      = (state_q == ST_BUSY);
  assign last_beat = (idx_q == LAST_IDX);

  assign s_ready = ~rst & (~busy | (m_ready & last_beat));
  assign m_valid = busy;
  assign m_data  = slice[idx_q];
  assign m_last  = busy & lst_q & last_beat;

  assign w_hs = s_valid & s_ready;
  assign r_hs = m_valid & m_ready;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    buf_d   = buf_q;
    lst_d   = lst_q;
    case (state_q)
      ST_IDLE: begin
        if (w_hs) begin
          state_d = ST_BUSY;
          buf_d   = s_data;
          lst_d   = s_last;
          idx_d   = '0;
        end
      end
      ST_BUSY: begin
        if (r_hs) begin
          if (!last_beat) begin
            idx_d = idx_q + LOG2RATIO'(1);
          end else if (w_hs) begin
            buf_d = s_data;
            lst_d = s_last;
            idx_d = '0;
          end else begin
            state_d = ST_IDLE;
            idx_d   = '0;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      buf_q   <= '0;
      lst_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
      lst_q   <= lst_d;
    end
  end

endmodule

// File: tb/tb_stream_downsizer.sv
// Self-checking bench for stream_downsizer: directed scenarios plus a random soak,
// with a scoreboard queue of expected {beat, last} pairs filled on every accept.
module tb_stream_downsizer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        s_valid = 1'b0;
  logic        s_last  = 1'b0;
  logic [31:0] s_data  = '0;
  logic        m_ready = 1'b0;
  logic        s_ready;
  logic        m_valid;
  logic        m_last;
  logic [7:0]  m_data;

  logic        s_valid1 = 1'b0;
  logic        s_last1  = 1'b0;
  logic [31:0] s_data1  = '0;
  logic        m_ready1 = 1'b0;
  logic        s_ready1;
  logic        m_valid1;
  logic        m_last1;
  logic [7:0]  m_data1;

  int checks   = 0;
  int failures = 0;

  logic [8:0] exp_q[$];
  bit         mon_en  = 1'b0;
  bit         verbose = 1'b1;

  always #5 clk = ~clk;

  stream_downsizer #(.IN_SIZE(32), .OUT_SIZE(8), .MSB_FIRST(1'b0)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
  );

  stream_downsizer #(.IN_SIZE(32), .OUT_SIZE(8), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst(rst),
    .s_valid(s_valid1), .s_ready(s_ready1), .s_data(s_data1), .s_last(s_last1),
    .m_valid(m_valid1), .m_ready(m_ready1), .m_data(m_data1), .m_last(m_last1)
  );

  // Runs at every falling edge: compares leaving beats against the queue, checks
  // that a stalled beat stays put, and queues the beats of any word about to be taken.
  task automatic monitor();
    logic [8:0] e;
    logic       pend;
    logic [7:0] pd;
    logic       pl;
    pend = 1'b0;
    pd   = '0;
    pl   = 1'b0;
    forever begin
      @(negedge clk);
      if (!mon_en || rst) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          checks++;
          if (m_valid !== 1'b1 || m_data !== pd || m_last !== pl) begin
            failures++;
            $display("FAIL hold: got v=%b d=%h l=%b, need v=1 d=%h l=%b",
                     m_valid, m_data, m_last, pd, pl);
          end
        end
        if (m_valid === 1'b1 && m_ready === 1'b1) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL sb_extra: got d=%h l=%b, need no beat", m_data, m_last);
          end else begin
            e = exp_q.pop_front();
            if ({m_data, m_last} !== e) begin
              failures++;
              $display("FAIL sb_beat: got d=%h l=%b, need d=%h l=%b",
                       m_data, m_last, e[8:1], e[0]);
            end else if (verbose) begin
              $display("beat d=%h l=%b", m_data, m_last);
            end
          end
        end
        if (s_valid === 1'b1 && s_ready === 1'b1) begin
          for (int k = 0; k < 4; k++) begin
            exp_q.push_back({s_data[8*k +: 8], (k == 3) && s_last});
          end
        end
        pend = (m_valid === 1'b1) && (m_ready !== 1'b1);
        pd   = m_data;
        pl   = m_last;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    s_valid = 1'b0;
    m_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (s_ready !== 1'b0) begin
      failures++;
      $display("FAIL rst_s_ready_low: got %b, need 0", s_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b0 || m_last !== 1'b0 || m_data !== 8'h00) begin
      failures++;
      $display("FAIL rst_outputs: got v=%b l=%b d=%h, need v=0 l=0 d=00", m_valid, m_last, m_data);
    end
    checks++;
    if (s_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_s_ready: got %b, need 1", s_ready);
    end
    checks++;
    if (m_valid1 !== 1'b0 || m_data1 !== 8'h00 || s_ready1 !== 1'b1) begin
      failures++;
      $display("FAIL rst_msb_outputs: got v=%b d=%h r=%b, need v=0 d=00 r=1", m_valid1, m_data1, s_ready1);
    end
    $display("reset done");
  endtask

  // Sends one word with m_ready high and checks four back-to-back beats, then idle.
  task automatic send_single(input logic [31:0] w, input string tag);
    @(posedge clk); #1;
    s_valid = 1'b1;
    s_data  = w;
    s_last  = 1'b0;
    m_ready = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (m_valid !== 1'b1) begin
        failures++;
        $display("FAIL %s_valid_beat%0d: got %b, need 1", tag, k, m_valid);
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_done: got v=%b pending=%0d, need v=0 pending=0", tag, m_valid, exp_q.size());
    end
  endtask

  task automatic test_single_word();
    send_single(32'hDDCCBBAA, "single");
    $display("single word done");
  endtask

  task automatic test_back_to_back();
    int  nwords;
    int  run;
    int  maxrun;
    bit  saw44;
    bit  acc;
    nwords = 0;
    run    = 0;
    maxrun = 0;
    saw44  = 1'b0;
    @(posedge clk); #1;
    s_valid = 1'b1;
    s_data  = 32'h44332211;
    s_last  = 1'b0;
    m_ready = 1'b1;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      acc = s_valid && s_ready;
      if (m_valid === 1'b1) begin
        run++;
        if (m_data === 8'h44) begin
          saw44 = 1'b1;
          checks++;
          if (s_ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_s_ready_on_44: got %b, need 1", s_ready);
          end
        end
      end else begin
        if (run > maxrun) maxrun = run;
        run = 0;
      end
      @(posedge clk); #1;
      if (acc) begin
        nwords++;
        if (nwords == 1) begin
          s_data = 32'h88776655;
          s_last = 1'b1;
        end else begin
          s_valid = 1'b0;
        end
      end
    end
    if (run > maxrun) maxrun = run;
    checks++;
    if (maxrun != 8 || !saw44) begin
      failures++;
      $display("FAIL b2b_run: got run=%0d saw44=%b, need run=8 saw44=1", maxrun, saw44);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL b2b_drain: got pending=%0d, need 0", exp_q.size());
    end
    $display("back to back done");
  endtask

  task automatic test_backpressure();
    bit pat [7];
    int beats;
    bit exp_rdy;
    logic [7:0] pd;
    logic pl;
    pat   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    beats = 0;
    pd    = '0;
    pl    = 1'b0;
    @(posedge clk); #1;
    s_valid = 1'b1;
    s_data  = 32'hDDCCBBAA;
    s_last  = 1'b0;
    m_ready = 1'b0;
    @(posedge clk); #1;
    s_valid = 1'b0;
    m_ready = pat[0];
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      checks++;
      if (m_valid !== 1'b1) begin
        failures++;
        $display("FAIL bp_valid%0d: got %b, need 1", i, m_valid);
      end
      if (i > 0 && !pat[i-1]) begin
        checks++;
        if (m_data !== pd || m_last !== pl) begin
          failures++;
          $display("FAIL bp_stable%0d: got d=%h l=%b, need d=%h l=%b", i, m_data, m_last, pd, pl);
        end
      end
      exp_rdy = (beats == 3) && pat[i];
      checks++;
      if (s_ready !== exp_rdy) begin
        failures++;
        $display("FAIL bp_s_ready%0d: got %b, need %b", i, s_ready, exp_rdy);
      end
      pd = m_data;
      pl = m_last;
      @(posedge clk); #1;
      if (pat[i]) beats++;
      if (i < 6) m_ready = pat[i+1];
    end
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL bp_done: got v=%b pending=%0d, need v=0 pending=0", m_valid, exp_q.size());
    end
    $display("backpressure done");
  endtask

  task automatic test_msb_first();
    logic [8:0] exp1[$];
    logic [8:0] e;
    int got;
    bit acc;
    got = 0;
    @(posedge clk); #1;
    s_valid1 = 1'b1;
    s_data1  = 32'hDDCCBBAA;
    s_last1  = 1'b1;
    m_ready1 = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      acc = s_valid1 && s_ready1;
      if (m_valid1 === 1'b1 && m_ready1 === 1'b1) begin
        checks++;
        got++;
        if (exp1.size() == 0) begin
          failures++;
          $display("FAIL msb_extra: got d=%h, need no beat", m_data1);
        end else begin
          e = exp1.pop_front();
          if ({m_data1, m_last1} !== e) begin
            failures++;
            $display("FAIL msb_beat: got d=%h l=%b, need d=%h l=%b", m_data1, m_last1, e[8:1], e[0]);
          end else begin
            $display("msb beat d=%h l=%b", m_data1, m_last1);
          end
        end
      end
      if (acc) begin
        exp1.push_back({8'hDD, 1'b0});
        exp1.push_back({8'hCC, 1'b0});
        exp1.push_back({8'hBB, 1'b0});
        exp1.push_back({8'hAA, 1'b1});
      end
      @(posedge clk); #1;
      if (acc) s_valid1 = 1'b0;
    end
    checks++;
    if (got != 4 || exp1.size() != 0) begin
      failures++;
      $display("FAIL msb_count: got beats=%0d pending=%0d, need beats=4 pending=0", got, exp1.size());
    end
  endtask

  task automatic test_reset_midword();
    @(posedge clk); #1;
    s_valid = 1'b1;
    s_data  = 32'hDDCCBBAA;
    s_last  = 1'b0;
    m_ready = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    mon_en = 1'b0;
    rst    = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    mon_en = 1'b1;
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b0) begin
      failures++;
      $display("FAIL midrst_valid: got %b, need 0", m_valid);
    end
    send_single(32'h04030201, "midrst");
    $display("reset mid-word done");
  endtask

  task automatic test_soak();
    int  sent;
    int  cyc;
    bit  acc;
    sent    = 0;
    cyc     = 0;
    verbose = 1'b0;
    @(posedge clk); #1;
    s_valid = 1'b0;
    while (sent < 10000 && cyc < 60000) begin
      @(negedge clk);
      acc = s_valid && s_ready;
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        sent++;
        s_valid = 1'b0;
      end
      if (!s_valid && sent < 10000 && $urandom_range(7) != 0) begin
        s_valid = 1'b1;
        s_data  = $urandom;
        s_last  = 1'($urandom_range(1));
      end
      m_ready = ($urandom_range(15) != 0);
    end
    s_valid = 1'b0;
    checks++;
    if (sent != 10000) begin
      failures++;
      $display("FAIL soak_budget: got words=%0d, need 10000", sent);
    end
    m_ready = 1'b1;
    for (int c = 0; c < 20 && (exp_q.size() != 0 || m_valid === 1'b1); c++) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || m_valid !== 1'b0) begin
      failures++;
      $display("FAIL soak_drain: got pending=%0d v=%b, need pending=0 v=0", exp_q.size(), m_valid);
    end
    $display("soak done: %0d words in %0d cycles", sent, cyc);
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    mon_en = 1'b1;
    test_single_word();
    test_back_to_back();
    test_backpressure();
    test_msb_first();
    test_reset_midword();
    test_soak();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
